seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
Multi-cycle unsigned divider that undoes the four-bit adder: it computes quotient and remainder by restoring shift-subtract, one quotient bit per clock. Operands are accepted on a start/busy/done handshake, so the block can sit next to the adder datapath without combinational depth growing with WIDTH. Divide-by-zero is detected up front and flagged.

Parameters:
WIDTH, 4, operand, quotient and remainder width in bits (must be 2 or more).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  request a division; sampled only in IDLE.
dividend  input  WIDTH  unsigned dividend; sampled with start.
divisor  input  WIDTH  unsigned divisor; sampled with start.
busy  output  1  high while an operation is in progress (CALC).
done  output  1  single-cycle pulse; results are valid from this cycle onward.
quotient  output  WIDTH  registered quotient.
remainder  output  WIDTH  registered remainder.
div_by_zero  output  1  set with done when the divisor was 0.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Reset asserted mid-operation aborts immediately: all outputs return to reset values and no done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and divisor!=0 at edge k: latch D=divisor, Q=dividend, R=0, count=0. Go to CALC; busy=1 after edge k.
  - start=1 and divisor==0 at edge k: go to DONE. quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1, done=1 after edge k.
- CALC, one iteration per edge:
  - {R,Q} shifted left by 1, R taking Q's MSB.
  - trial = R_shifted - D, computed WIDTH+1 bits wide.
  - trial non-negative (MSB 0): R=trial[WIDTH-1:0] and Q[0]=1. Otherwise R is unchanged and Q[0]=0.
  - Iterations run on edges k+1..k+WIDTH. At edge k+WIDTH: quotient=Q, remainder=R, div_by_zero=0, done=1, busy=0, state to DONE.
- DONE: lasts exactly one cycle, then IDLE at the next edge; done returns to 0.
- Outputs: quotient, remainder and div_by_zero hold until the next completion or reset. They are not cleared when a new start is accepted.
- start is ignored in CALC and DONE: no queuing and no error.
  - A new start is accepted in the first IDLE cycle after DONE.
  - Minimum start-to-start spacing is WIDTH+2 cycles (normal) or 2 cycles (divide-by-zero).
- Operand changes after acceptance have no effect.
- Invariants: at done with div_by_zero=0, dividend == quotient*divisor + remainder and remainder < divisor.

Decomposition:
- Shared package div_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - DEFAULT_WIDTH=4;
  - count width, defined as $clog2(WIDTH+1).
- One combinational sub-module is natural: div_sub_stage. It takes R_shifted and D, and returns the restored or subtracted R and the quotient bit.

Test Plan:
1. WIDTH=4, dividend=0xD, divisor=0x3, start pulse -> busy for 4 cycles; done exactly 4 edges after acceptance; quotient=0x4, remainder=0x1, div_by_zero=0.
2. 0xF/0x1 -> quotient=0xF, remainder=0x0. 0xF/0xF -> quotient=0x1, remainder=0x0. 0x7/0x9 -> quotient=0x0, remainder=0x7.
3. dividend=0xA, divisor=0x0 -> done one edge after start with busy never high; quotient=0xF, remainder=0xA, div_by_zero=1.
4. Start 0xC/0x5, then re-pulse start with 0x1/0x1 during CALC -> result quotient=0x2, remainder=0x2; only one done pulse.
5. Drop rst_n during CALC -> busy, done and all outputs go to 0 immediately. After release, 0x9/0x2 -> quotient=0x4, remainder=0x1.
6. Exhaustive sweep of all 256 operand pairs, back-to-back with start held high -> every result satisfies the invariants; divisor=0 cases flagged; spacing of done pulses matches the spacing rule.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e     : controller states (IDLE, CALC, DONE)
//   DEFAULT_WIDTH : default operand width
//   div_cnt_w() : width of the iteration counter for a given operand width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must be able to hold 0..WIDTH.
  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_sub_stage.sv
// One restoring shift-subtract step, purely combinational.
// Ports:
//   r_shifted [WIDTH:0]   partial remainder after the left shift (R, Q msb)
//   d         [WIDTH-1:0] divisor
//   r_next    [WIDTH-1:0] remainder after subtract-or-restore
//   q_bit                 quotient bit produced by this step
module div_sub_stage
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   r_shifted,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  always_comb begin
    // One extra bit so the borrow shows up as the msb.
    trial = r_shifted - {1'b0, d};
    q_bit = ~trial[WIDTH];
    // On a borrow the shifted remainder is kept; it is below d, so it
    // always fits in WIDTH bits.
    r_next = trial[WIDTH] ? r_shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   start                 request; sampled only while idle
//   dividend, divisor     operands, sampled with an accepted start
//   busy                  high while iterating
//   done                  one-cycle completion pulse
//   quotient, remainder   registered results, held until next completion
//   div_by_zero           set with done when the divisor was zero
// A zero divisor completes on the accepting edge with quotient all ones
// and remainder equal to the dividend.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] wq_q, wq_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shifted;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;
  logic [WIDTH-1:0] wq_next;

  // {R,Q} shifted left as one register pair: R picks up Q's msb.
  assign r_shifted = {r_q, wq_q[WIDTH-1]};
  assign wq_next   = {wq_q[WIDTH-2:0], q_bit};

  div_sub_stage #(
    .WIDTH(WIDTH)
  ) u_sub (
    .r_shifted(r_shifted),
    .d        (dvsr_q),
    .r_next   (r_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_d     = state_q;
    dvsr_d      = dvsr_q;
    wq_d        = wq_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            dvsr_d  = divisor;
            wq_d    = dividend;
            r_d     = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        wq_d  = wq_next;
        r_d   = r_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          quotient_d  = wq_next;
          remainder_d = r_next;
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvsr_q      <= '0;
      wq_q        <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvsr_q      <= dvsr_d;
      wq_q        <= wq_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4): directed cases,
// mid-operation start and reset, a back-to-back sweep of all operand pairs
// and random operations, all checked against plain integer division.
module tb_seq_restoring_divider;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference: integer division, divide-by-zero gives all-ones / dividend.
  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? MAXV : a / b;
  endfunction
  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction
  function automatic int ref_lat(input int b);
    return (b == 0) ? 0 : W;
  endfunction

  task automatic check_result(input string tag, input int a, input int b);
    chk({tag, ".q"}, 32'(quotient), 32'(ref_q(a, b)));
    chk({tag, ".r"}, 32'(remainder), 32'(ref_r(a, b)));
    chk({tag, ".dbz"}, 32'(div_by_zero), 32'(b == 0));
    if (b != 0) begin
      chk({tag, ".inv_eq"}, 32'(int'(quotient) * b + int'(remainder)), 32'(a));
      chk({tag, ".inv_lt"}, 32'(int'(remainder) < b), 32'd1);
    end
  endtask

  // Single operation from IDLE: one-cycle start pulse, latency, busy length,
  // results and single-cycle done are all checked.
  task automatic run_op(input string tag, input int a, input int b);
    int lat, busy_cnt;
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(ref_lat(b)));
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(ref_lat(b)));
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check_result(tag, a, b);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int a, b, lat, ndone, prev_done, exp_gap;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.q", 32'(quotient), 32'd0);
    chk("rst.r", 32'(remainder), 32'd0);
    chk("rst.dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op("d13_3", 13, 3);
    run_op("d15_1", 15, 1);
    run_op("d15_15", 15, 15);
    run_op("d7_9", 7, 9);
    run_op("d10_0", 10, 0);
    run_op("d0_5", 0, 5);

    // Start re-pulsed during CALC is ignored
    dividend = 4'hC;
    divisor  = 4'h5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 4'h1;
    divisor  = 4'h1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        ndone++;
        chk("busy_ign.q", 32'(quotient), 32'd2);
        chk("busy_ign.r", 32'(remainder), 32'd2);
      end
      @(negedge clk);
    end
    chk("busy_ign.ndone", 32'(ndone), 32'd1);

    // Asynchronous reset mid-operation
    run_op("pre_rst", 14, 3);
    dividend = 4'hB;
    divisor  = 4'h2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    chk("arst.q", 32'(quotient), 32'd0);
    chk("arst.r", 32'(remainder), 32'd0);
    chk("arst.dbz", 32'(div_by_zero), 32'd0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("arst.no_activity", 32'(ndone), 32'd0);
    run_op("post_rst", 9, 2);

    // Back-to-back sweep of all operand pairs with start held high;
    // next operands are presented as soon as the previous done is seen.
    prev_done = -1;
    dividend = 4'h0;
    divisor  = 4'h0;
    start    = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = i / 16;
      b = i % 16;
      lat = 0;
      @(negedge clk);
      while (!done && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk("sweep.seen_done", 32'(done), 32'd1);
      check_result("sweep", a, b);
      if (prev_done >= 0) begin
        exp_gap = 2 + ref_lat(b);
        chk("sweep.gap", 32'(cyc - prev_done), 32'(exp_gap));
      end
      prev_done = cyc;
      if (i < 255) begin
        dividend = W'((i + 1) / 16);
        divisor  = W'((i + 1) % 16);
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("sweep.end_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);

    // Random operations, including extra divide-by-zero weight
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, MAXV);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MAXV);
      run_op("rand", a, b);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: got %0d cycles want completion", cyc);
    $fatal(1, "time limit reached");
  end

endmodule
